// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths, constants, flag indices and operand classes.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  // Bit positions inside the 3-bit {NV, OF, Z} flag vector.
  localparam int FLG_NV = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_Z  = 0;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies one single-precision operand; denormals are treated as zero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] x,
  output fp_class_t   cls
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;
  logic             sign_unused;

  assign exp_field   = x[30:23];
  assign man_field   = x[22:0];
  assign sign_unused = x[31];

  always_comb begin
    cls = NORM;
    if (exp_field == '0) begin
      cls = ZERO;
    end else if (exp_field == EXP_MAX) begin
      cls = (man_field == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fp_add_stage.sv
// Two-entry execute stage around an external combinational FP adder, with special-case override.
// Optional FP_ADD_STAGE_PERF_EN adds perf_ops / perf_special counters.
module fp_add_stage #(
  parameter logic [31:0] QNAN = fp_pkg::QNAN,
  parameter int          RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic            in_op,
  input  logic [RD_W-1:0] in_rd,
  output logic [31:0]     adder_fa,
  output logic [31:0]     adder_fb,
  output logic            adder_op,
  input  logic [31:0]     adder_fs,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic [2:0]      out_flags
`ifdef FP_ADD_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_special
`endif
);

  import fp_pkg::*;

  logic            s1_valid;
  logic [RD_W-1:0] s1_rd;
  logic            s2_valid;
  logic            s2_adv;
  logic            s1_adv;
  logic            transfer;

  fp_class_t        cls_a;
  fp_class_t        cls_b;
  logic             sign_a;
  logic             sign_b;
  logic [EXP_W-1:0] exp_hi;
  logic             fs_ovf;

  logic [31:0] res_next;
  logic [2:0]  flags_next;
  logic        nv_next;
  logic        of_next;
  logic        special_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s2_adv;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;
  assign transfer  = s1_valid && s1_adv && !flush;

  fp_classify u_cls_a (.x(adder_fa), .cls(cls_a));
  fp_classify u_cls_b (.x(adder_fb), .cls(cls_b));

  assign sign_a = adder_fa[31];
  assign sign_b = adder_fb[31] ^ adder_op;
  assign exp_hi = (adder_fa[30:23] > adder_fb[30:23]) ? adder_fa[30:23] : adder_fb[30:23];

  // A wrapping adder can report an overflow from the top binade as a small nonzero exponent-0 value.
  assign fs_ovf = (adder_fs[30:23] == EXP_MAX) ||
                  ((exp_hi == EXP_MAX - 8'd1) && (adder_fs[30:23] == '0) && (adder_fs != '0));

  always_comb begin
    res_next     = adder_fs;
    nv_next      = 1'b0;
    of_next      = 1'b0;
    special_next = 1'b1;
    if (cls_a == NAN || cls_b == NAN) begin
      res_next = QNAN;
      nv_next  = 1'b1;
    end else if (cls_a == INF && cls_b == INF && sign_a != sign_b) begin
      res_next = QNAN;
      nv_next  = 1'b1;
    end else if (cls_a == INF) begin
      res_next = adder_fa;
    end else if (cls_b == INF) begin
      res_next = {sign_b, EXP_MAX, {MAN_W{1'b0}}};
    end else if (cls_a == ZERO && cls_b == ZERO) begin
      res_next = {sign_a & sign_b, 31'b0};
    end else if (cls_a == ZERO) begin
      res_next = {sign_b, adder_fb[30:0]};
    end else if (cls_b == ZERO) begin
      res_next = adder_fa;
    end else if (fs_ovf) begin
      res_next = {adder_fs[31], EXP_MAX, {MAN_W{1'b0}}};
      of_next  = 1'b1;
    end else begin
      special_next = 1'b0;
    end
    flags_next         = 3'b000;
    flags_next[FLG_NV] = nv_next;
    flags_next[FLG_OF] = of_next;
    flags_next[FLG_Z]  = (res_next[30:0] == 31'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      adder_fa   <= '0;
      adder_fb   <= '0;
      adder_op   <= 1'b0;
      s1_rd      <= '0;
      out_result <= '0;
      out_rd     <= '0;
      out_flags  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s1_valid && s1_adv) begin
        out_result <= res_next;
        out_rd     <= s1_rd;
        out_flags  <= flags_next;
      end
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        adder_fa <= in_a;
        adder_fb <= in_b;
        adder_op <= in_op;
        s1_rd    <= in_rd;
      end
    end
  end

`ifdef FP_ADD_STAGE_PERF_EN
  // Counters survive flush: they count work that actually reached S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops     <= '0;
      perf_special <= '0;
    end else if (transfer) begin
      perf_ops <= perf_ops + 32'd1;
      if (special_next) begin
        perf_special <= perf_special + 32'd1;
      end
    end
  end
`else
  logic perf_unused;
  assign perf_unused = transfer ^ special_next;
`endif

endmodule

// File: tb/tb_fp_add_stage.sv
// Self-checking bench for fp_add_stage: directed vector table, pipeline corner sequences,
// and randomized traffic against a scoreboard. Perf checks are active under FP_ADD_STAGE_PERF_EN.
module tb_fp_add_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic [4:0]  in_rd;
  logic [31:0] adder_fa;
  logic [31:0] adder_fb;
  logic        adder_op;
  logic [31:0] adder_fs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [2:0]  out_flags;
`ifdef FP_ADD_STAGE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_special;
`endif

  logic        force_en;
  logic [31:0] force_val;

  int n_checks;
  int n_fail;

  fp_add_stage #(.QNAN(32'h7FC0_0000), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rd(in_rd),
    .adder_fa(adder_fa), .adder_fb(adder_fb), .adder_op(adder_op), .adder_fs(adder_fs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_flags(out_flags)
`ifdef FP_ADD_STAGE_PERF_EN
    , .perf_ops(perf_ops), .perf_special(perf_special)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural FP adder (via double-precision reals) ----------------
  function automatic real s2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'h00) return 0.0;
    e = (x[30:23] == 8'hFF) ? 11'h7FF : 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, 23'b0};
    e   = int'(d[62:52]) - 896;
    m   = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    real rb;
    rb = op ? -s2r(b) : s2r(b);
    return r2s(s2r(a) + rb);
  endfunction

  assign adder_fs = force_en ? force_val : fadd(adder_fa, adder_fb, adder_op);

  // ---------------- reference: the stage's result rules on whole operands ----------------
  task automatic ref_add(input logic [31:0] a, input logic [31:0] b, input logic op,
                         output logic [31:0] res, output logic [2:0] flg);
    logic sa, sb, za, zb, ia, ib, na, nb;
    logic [31:0] fs;
    logic [7:0] ehi;
    sa = a[31];
    sb = b[31] ^ op;
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    ehi = (a[30:23] > b[30:23]) ? a[30:23] : b[30:23];
    flg = 3'b000;
    if (na || nb) begin res = 32'h7FC0_0000; flg[2] = 1'b1; end
    else if (ia && ib && sa != sb) begin res = 32'h7FC0_0000; flg[2] = 1'b1; end
    else if (ia) res = a;
    else if (ib) res = {sb, 8'hFF, 23'h0};
    else if (za && zb) res = {sa & sb, 31'b0};
    else if (za) res = {sb, b[30:0]};
    else if (zb) res = a;
    else begin
      fs = fadd(a, b, op);
      if (fs[30:23] == 8'hFF || (ehi == 8'hFE && fs[30:23] == 8'h00 && fs != 32'h0)) begin
        res = {fs[31], 8'hFF, 23'h0};
        flg[1] = 1'b1;
      end else res = fs;
    end
    if (res[30:0] == 31'b0) flg[0] = 1'b1;
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op into an otherwise idle pipeline with out_ready=1; checks the two-cycle latency.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [4:0] rd,
                         input logic [31:0] exp_res, input logic [2:0] exp_flg);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_rd = rd;
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({name, "_lat1_invalid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_in_ready_s1"}, {31'b0, in_ready}, 32'd1);
    tick();
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_flags"}, {29'b0, out_flags}, {29'b0, exp_flg});
    chk({name, "_rd"}, {27'b0, out_rd}, {27'b0, rd});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
    logic        spec;
  } vec_t;

  vec_t vecs[16];

  // ---------------- random scoreboard ----------------
  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    m = 23'($urandom);
    case ($urandom_range(0, 7))
      0: e = 8'h00;
      1: begin e = 8'hFF; m = 23'h0; end
      2: begin e = 8'hFF; m[0] = 1'b1; end
      3: e = 8'hFE;
      4, 5: e = 8'($urandom_range(120, 134));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Called #1 after inputs are driven for a cycle; checks outputs and advances the model to the next edge.
  task automatic observe();
    exp_t e;
    chk("sb_in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < 2) || out_ready});
    if (sb.size() == 0) begin
      chk("sb_idle_valid", {31'b0, out_valid}, 32'd0);
    end else if (out_valid) begin
      chk("sb_result", out_result, sb[0].res);
      chk("sb_flags", {29'b0, out_flags}, {29'b0, sb[0].flg});
      chk("sb_rd", {27'b0, out_rd}, {27'b0, sb[0].rd});
    end
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) begin
        ref_add(in_a, in_b, in_op, e.res, e.flg);
        e.rd = in_rd;
        sb.push_back(e);
      end
    end
  endtask

  logic [31:0] bp_exp[3];
  int          got;
  int          first_cyc;
  int          last_cyc;
  logic        acc3;
  logic [31:0] held;
`ifdef FP_ADD_STAGE_PERF_EN
  logic [31:0] snap_ops;
  logic [31:0] snap_spec;
  int          spec_cnt;
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_rd = '0;
    out_ready = 1'b1; force_en = 1'b0; force_val = '0;

    vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, 1'b0};
    vecs[1]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100, 1'b1};
    vecs[2]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b100, 1'b1};
    vecs[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010, 1'b1};
    vecs[4]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b001, 1'b0};
    vecs[5]  = '{32'h0000_0001, 32'h4000_0000, 1'b0, 32'h4000_0000, 3'b000, 1'b1};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 3'b001, 1'b1};
    vecs[7]  = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 3'b000, 1'b1};
    vecs[8]  = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 3'b000, 1'b1};
    vecs[9]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 3'b000, 1'b1};
    vecs[10] = '{32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 3'b000, 1'b1};
    vecs[11] = '{32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h3F80_0000, 3'b000, 1'b1};
    vecs[12] = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000, 3'b000, 1'b0};
    vecs[13] = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 3'b000, 1'b0};
    vecs[14] = '{32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 3'b000, 1'b0};
    vecs[15] = '{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 3'b001, 1'b1};

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_out_flags", {29'b0, out_flags}, 32'd0);
    chk("rst_adder_fa", adder_fa, 32'd0);
    chk("rst_adder_fb", adder_fb, 32'd0);
    chk("rst_adder_op", {31'b0, adder_op}, 32'd0);
`ifdef FP_ADD_STAGE_PERF_EN
    chk("rst_perf_ops", perf_ops, 32'd0);
    chk("rst_perf_special", perf_special, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Directed table.
`ifdef FP_ADD_STAGE_PERF_EN
    snap_ops = perf_ops; snap_spec = perf_special; spec_cnt = 0;
`endif
    for (int i = 0; i < 16; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, 5'(i),
              vecs[i].res, vecs[i].flg);
`ifdef FP_ADD_STAGE_PERF_EN
      if (vecs[i].spec) spec_cnt++;
`endif
    end
`ifdef FP_ADD_STAGE_PERF_EN
    chk("perf_ops_table", perf_ops - snap_ops, 32'd16);
    chk("perf_special_table", perf_special - snap_spec, 32'(spec_cnt));
`endif
    idle(3);

    // Forced adder outputs: wrapped overflow, signed-zero sum, and plain passthrough.
    force_en = 1'b1;
    force_val = 32'h0012_3456;
    run_one("wrap_ovf", 32'h7F00_0000, 32'h7F00_0000, 1'b0, 5'd20, 32'h7F80_0000, 3'b010);
    idle(2);
    run_one("small_exp0", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd21, 32'h0012_3456, 3'b000);
    idle(2);
    force_val = 32'h8000_0000;
    run_one("neg_zero_sum", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 5'd22, 32'h8000_0000, 3'b001);
    force_en = 1'b0;
    idle(3);

    // Backpressure: three back-to-back ops with out_ready low for four cycles.
    bp_exp[0] = 32'h4000_0000; bp_exp[1] = 32'h4040_0000; bp_exp[2] = 32'h4080_0000;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_op = 1'b0; in_rd = 5'd1;
    #1 chk("bp_ready_acc1", {31'b0, in_ready}, 32'd1);
    tick();
    in_a = 32'h4000_0000; in_rd = 5'd2;
    #1 chk("bp_ready_acc2", {31'b0, in_ready}, 32'd1);
    tick();
    in_a = 32'h4040_0000; in_rd = 5'd3;
    #1;
    held = out_result;
    for (int k = 0; k < 4; k++) begin
      chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
      chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
      chk("bp_result_held", out_result, bp_exp[0]);
      chk("bp_result_stable", out_result, held);
      chk("bp_rd_held", {27'b0, out_rd}, 32'd1);
      tick();
      #1;
    end
    out_ready = 1'b1;
    #1;
    got = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 12 && got < 3; c++) begin
      acc3 = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("bp_drain%0d", got), out_result, bp_exp[got]);
        chk($sformatf("bp_drain_rd%0d", got), {27'b0, out_rd}, 32'(got + 1));
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
      end
      @(posedge clk);
      #1;
      if (acc3) in_valid = 1'b0;
      #1;
    end
    chk("bp_drain_count", 32'(got), 32'd3);
    chk("bp_drain_back_to_back", 32'(last_cyc - first_cyc), 32'd2);
    idle(3);

    // Flush with both stages full and an op on the input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_op = 1'b0; in_rd = 5'd7;
    tick();
    in_rd = 5'd8;
    tick();
`ifdef FP_ADD_STAGE_PERF_EN
    snap_ops = perf_ops;
`endif
    chk("fl_full_valid", {31'b0, out_valid}, 32'd1);
    in_rd = 5'd9; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_kill", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl_no_emit", {31'b0, out_valid}, 32'd0);
    end
`ifdef FP_ADD_STAGE_PERF_EN
    chk("fl_perf_ops", perf_ops, snap_ops);
`endif
    // Flush on an empty pipeline discards the same-cycle accept.
    in_valid = 1'b1; flush = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_accept_dropped", {31'b0, out_valid}, 32'd0);
    end
    run_one("after_flush", 32'h40A0_0000, 32'h3F80_0000, 1'b0, 5'd11, 32'h40C0_0000, 3'b000);
    idle(3);

    // Randomized traffic with backpressure and occasional flush.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = rand_fp();
      in_b      = ($urandom_range(0, 7) == 0) ? in_a : rand_fp();
      in_op     = 1'($urandom);
      in_rd     = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (flush) out_ready = 1'b0;
      #1;
      observe();
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      #1;
      observe();
      tick();
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    #1 chk("sb_final_idle", {31'b0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_stage.md
Name: fp_add_stage

Overview:
- Pipelined execute-stage wrapper around the combinational single-precision add/sub datapath (FP_adder) in the RISC-V pipeline CPU.
- Accepts operands from the issue stage via valid/ready and registers them.
- Drives the external adder and registers its result.
- Overrides special cases the adder does not handle: NaN, Inf, zero, denormal, overflow. Delivers result plus flags to writeback via valid/ready.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet NaN returned on invalid operations.
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills all in-flight ops
- in_valid  in  1  operand request valid
- in_ready  out  1  stage can accept operands
- in_a  in  32  operand A, IEEE-754 single
- in_b  in  32  operand B, IEEE-754 single
- in_op  in  1  0 = add, 1 = sub
- in_rd  in  RD_W  destination tag
- adder_fa  out  32  to adder FA (S1 register)
- adder_fb  out  32  to adder FB (S1 register)
- adder_op  out  1  to adder op (S1 register)
- adder_fs  in  32  adder result FS (combinational)
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts
- out_result  out  32  final result
- out_rd  out  RD_W  destination tag
- out_flags  out  3  {NV invalid, OF overflow, Z zero}

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_rd=0, out_flags=0, adder_fa/fb=0, adder_op=0.
- Two-entry pipeline S1 → S2:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = s2_adv
  - in_ready = !s1_valid | s1_adv (combinational, no flush term)
- Accept: in_valid & in_ready & !flush → S1 captures a, b, op, rd; s1_valid=1.
- S1→S2 transfer: on s1_valid & s1_adv, S2 captures override-or-adder result, rd and flags. Latency = 2 cycles from accept to out_valid with no backpressure. Throughput = 1/cycle.
- Stall: out_valid & !out_ready holds S2 and S1 stable. out_result, out_rd and out_flags must not change while stalled.
- Flush: s1_valid and s2_valid clear on the next edge. A same-cycle accept is discarded. Flush has priority over all other updates.
- Classification (sub-module, applied to S1 operands):
  - Effective B sign = b[31]^op.
  - Exp 0 → zero; mantissa ignored (denormals flush-to-zero).
  - Exp FF with mant 0 → Inf. Exp FF with mant ≠ 0 → NaN.
- S2 result priority, first match wins:
  1. Any NaN → QNAN, NV=1.
  2. Inf(A) and Inf(B) with opposite effective signs → QNAN, NV=1.
  3. Inf(A) → A. Inf(B) → {effB sign, FF, 0}.
  4. A and B both zero → {signA & effB, 31'b0}, Z=1.
  5. A zero → {effB sign, b[30:0]}. B zero → A.
  6. Otherwise adder_fs.
     - If adder_fs[30:23]==FF, or max(expA,expB)==FE and adder_fs[30:23]==00 with adder_fs≠0 → {adder_fs[31], FF, 0}, OF=1.
     - If adder_fs==0 → Z=1.
- Z is also set whenever the final result[30:0]==0.

Optional Feature:
- FP_ADD_STAGE_PERF_EN defined: adds outputs perf_ops[31:0] and perf_special[31:0].
  - perf_ops increments on each S1→S2 transfer.
  - perf_special increments when rule 1–5 or overflow fires.
  - Both counters are async-reset to 0, wrap at 2^32 and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fp_pkg:
  - Field widths EXP_W=8, MAN_W=23.
  - Constants EXP_MAX=8'hFF, QNAN.
  - Flag bit indices FLG_NV=2, FLG_OF=1, FLG_Z=0.
  - Typedef fp_class_t {ZERO, NORM, INF, NAN}.
- Sub-module fp_classify: one 32-bit input, fp_class_t output; instantiated twice.

Test Plan:
- 3F80_0000 + 4000_0000, out_ready=1 → 4040_0000 two cycles after accept, flags=000, in_ready stays 1.
- 7F80_0000 sub 7F80_0000 → 7FC0_0000, flags=100. 7FC0_0001 + 3F80_0000 → 7FC0_0000, NV=1.
- 7F7F_FFFF + 7F7F_FFFF → 7F80_0000, OF=1. 3F80_0000 sub 3F80_0000 → 0000_0000, Z=1.
- 0000_0001 (denormal) + 4000_0000 → 4000_0000. 8000_0000 sub 0000_0000 → 8000_0000, Z=1.
- 3 back-to-back accepts with out_ready=0 for 4 cycles:
  - in_ready drops after the 2nd accept.
  - out_result is held stable.
  - Releasing out_ready drains the results in order, one per cycle.
- Flush asserted while S1 and S2 are full and in_valid=1 → next cycle out_valid=0, no result emitted. With FP_ADD_STAGE_PERF_EN, perf_ops is unchanged by the flushed ops.
